// File: rtl/pwm_wta_ctrl.sv
// Winner-take-all sequencer across N_CH PWM channels: capture one full high-time per channel,
// then pick the largest via a shared comparator. Optional macro PWM_WTA_HYST_EN adds hysteresis.
module pwm_wta_ctrl #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned N_BIT   = 12,
  parameter int unsigned TIMEOUT = 50000,
  parameter int unsigned HYST    = 8,
  localparam int unsigned IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [N_CH-1:0]       i_pwm_fall,
  input  logic [N_CH*N_BIT-1:0] i_count,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [IDX_W-1:0]      o_winner,
  output logic [N_BIT-1:0]      o_win_count,
  output logic [N_CH-1:0]       o_valid_mask,
  output logic                  o_timeout
);

  typedef enum logic [1:0] {StIdle, StAcq, StCmp, StDone} state_e;

  state_e             state_q, state_d;
  logic [N_CH-1:0]    armed_q, armed_d;
  logic [N_CH-1:0]    capt_q, capt_d;
  logic [N_BIT-1:0]   cap_q [N_CH];
  logic [N_BIT-1:0]   cap_d [N_CH];
  logic [15:0]        tcnt_q, tcnt_d;
  logic               tflag_q, tflag_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               bv_q, bv_d;
  logic [IDX_W-1:0]   bi_q, bi_d;
  logic [N_BIT-1:0]   bc_q, bc_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [N_BIT-1:0]   wcnt_q, wcnt_d;
  logic [N_CH-1:0]    mask_q, mask_d;
  logic               tout_q, tout_d;

  logic               take;
  logic               nb_v;
  logic [IDX_W-1:0]   nb_i, sel_i;
  logic [N_BIT-1:0]   nb_c, sel_c;

`ifdef PWM_WTA_HYST_EN
  logic has_prev_q, has_prev_d;
`else
  logic [31:0] unused_hyst;
  assign unused_hyst = HYST;
`endif

  // Shared comparator: ties keep the lower index because only a strictly greater count wins.
  always_comb begin
    take = capt_q[idx_q] && (!bv_q || (cap_q[idx_q] > bc_q));
    nb_v = bv_q | take;
    nb_i = take ? idx_q : bi_q;
    nb_c = take ? cap_q[idx_q] : bc_q;
    sel_i = '0;
    sel_c = '0;
    if (nb_v) begin
      sel_i = nb_i;
      sel_c = nb_c;
    end
`ifdef PWM_WTA_HYST_EN
    if (has_prev_q && capt_q[win_q] &&
        ({1'b0, nb_c} < ({1'b0, cap_q[win_q]} + (N_BIT+1)'(HYST)))) begin
      sel_i = win_q;
      sel_c = cap_q[win_q];
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    capt_d  = capt_q;
    cap_d   = cap_q;
    tcnt_d  = tcnt_q;
    tflag_d = tflag_q;
    idx_d   = idx_q;
    bv_d    = bv_q;
    bi_d    = bi_q;
    bc_d    = bc_q;
    win_d   = win_q;
    wcnt_d  = wcnt_q;
    mask_d  = mask_q;
    tout_d  = tout_q;
`ifdef PWM_WTA_HYST_EN
    has_prev_d = has_prev_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          armed_d = '0;
          capt_d  = '0;
          tcnt_d  = '0;
          tflag_d = 1'b0;
          state_d = StAcq;
        end
      end
      StAcq: begin
        tcnt_d = tcnt_q + 16'd1;
        idx_d  = '0;
        bv_d   = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
          if (i_pwm_fall[k]) begin
            if (!armed_q[k]) begin
              armed_d[k] = 1'b1;
            end else if (!capt_q[k]) begin
              cap_d[k]  = i_count[k*N_BIT +: N_BIT];
              capt_d[k] = 1'b1;
            end
          end
        end
        if (&capt_q) begin
          state_d = StCmp;
        end else if (tcnt_q == 16'(TIMEOUT - 1)) begin
          tflag_d = 1'b1;
          state_d = StCmp;
        end
      end
      StCmp: begin
        bv_d  = nb_v;
        bi_d  = nb_i;
        bc_d  = nb_c;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(N_CH - 1)) begin
          // Results land here so they are already visible during the DONE pulse.
          win_d   = sel_i;
          wcnt_d  = sel_c;
          mask_d  = capt_q;
          tout_d  = tflag_q;
          state_d = StDone;
`ifdef PWM_WTA_HYST_EN
          has_prev_d = has_prev_q | nb_v;
`endif
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      armed_q <= '0;
      capt_q  <= '0;
      for (int k = 0; k < N_CH; k++) cap_q[k] <= '0;
      tcnt_q  <= '0;
      tflag_q <= 1'b0;
      idx_q   <= '0;
      bv_q    <= 1'b0;
      bi_q    <= '0;
      bc_q    <= '0;
      win_q   <= '0;
      wcnt_q  <= '0;
      mask_q  <= '0;
      tout_q  <= 1'b0;
`ifdef PWM_WTA_HYST_EN
      has_prev_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      capt_q  <= capt_d;
      cap_q   <= cap_d;
      tcnt_q  <= tcnt_d;
      tflag_q <= tflag_d;
      idx_q   <= idx_d;
      bv_q    <= bv_d;
      bi_q    <= bi_d;
      bc_q    <= bc_d;
      win_q   <= win_d;
      wcnt_q  <= wcnt_d;
      mask_q  <= mask_d;
      tout_q  <= tout_d;
`ifdef PWM_WTA_HYST_EN
      has_prev_q <= has_prev_d;
`endif
    end
  end

  assign o_busy       = (state_q != StIdle);
  assign o_done       = (state_q == StDone);
  assign o_winner     = win_q;
  assign o_win_count  = wcnt_q;
  assign o_valid_mask = mask_q;
  assign o_timeout    = tout_q;

endmodule

// File: tb/tb_pwm_wta_ctrl.sv
// Scoreboard bench for pwm_wta_ctrl (N_CH=4, N_BIT=12, TIMEOUT=1000, default build).
module tb_pwm_wta_ctrl;
  localparam int unsigned NCh = 4;
  localparam int unsigned NBit = 12;
  localparam int unsigned Tmo = 1000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_start = 1'b0;
  logic [NCh-1:0]  i_pwm_fall = '0;
  logic [NCh*NBit-1:0] i_count = '0;
  logic            o_busy, o_done, o_timeout;
  logic [1:0]      o_winner;
  logic [NBit-1:0] o_win_count;
  logic [NCh-1:0]  o_valid_mask;

  pwm_wta_ctrl #(.N_CH(NCh), .N_BIT(NBit), .TIMEOUT(Tmo), .HYST(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_pwm_fall   (i_pwm_fall),
    .i_count      (i_count),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_winner     (o_winner),
    .o_win_count  (o_win_count),
    .o_valid_mask (o_valid_mask),
    .o_timeout    (o_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int win;
    int cnt;
    int mask;
    int tout;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every o_done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && o_done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("winner", int'(o_winner), e.win);
        chk("win_count", int'(o_win_count), e.cnt);
        chk("valid_mask", int'(o_valid_mask), e.mask);
        chk("timeout", int'(o_timeout), e.tout);
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Holds inputs for exactly one clock; returns #1 after the sampling edge.
  task automatic drive(input bit st, input logic [3:0] f, input int c0, input int c1,
                       input int c2, input int c3);
    i_start    = st;
    i_pwm_fall = f;
    i_count    = {NBit'(c3), NBit'(c2), NBit'(c1), NBit'(c0)};
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'b0000, 0, 0, 0, 0);
  endtask

  task automatic push(input int w, input int c, input int m, input int t, input int at);
    exp_t e;
    e.win = w; e.cnt = c; e.mask = m; e.tout = t; e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic wait_empty(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      idle(1);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_wait_expired", sb.size(), 0);
      sb.delete();
    end
    idle(2);
  endtask

  int n;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    idle(1);
    rst = 1'b0;
    // Reset state
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_winner", int'(o_winner), 0);
    chk("rst_win_count", int'(o_win_count), 0);
    chk("rst_mask", int'(o_valid_mask), 0);
    chk("rst_timeout", int'(o_timeout), 0);

    // Round A: discard, capture 100/300/200/50, then stray second strobes
    drive(1'b1, 4'b0000, 0, 0, 0, 0);
    chk("busy_acq", int'(o_busy), 1);
    drive(1'b0, 4'b1111, 999, 999, 999, 999);
    n = cyc;
    drive(1'b0, 4'b1111, 100, 300, 200, 50);
    push(1, 300, 4'b1111, 0, n + 6);
    drive(1'b0, 4'b1111, 4000, 4000, 4000, 4000);
    wait_empty(50);
    chk("busy_idle", int'(o_busy), 0);

    // Round B: staggered strobes, tie 500/500/10/10, stray start during ACQ
    drive(1'b1, 4'b0000, 0, 0, 0, 0);
    drive(1'b0, 4'b0011, 1, 1, 1, 1);
    drive(1'b0, 4'b1100, 1, 1, 1, 1);
    drive(1'b0, 4'b0001, 500, 0, 0, 0);
    drive(1'b1, 4'b0000, 0, 0, 0, 0);
    drive(1'b0, 4'b0110, 0, 500, 10, 0);
    n = cyc;
    drive(1'b0, 4'b1000, 0, 0, 0, 10);
    push(0, 500, 4'b1111, 0, n + 6);
    wait_empty(50);

    // Round C: timeout with ch0/ch1 captured, ch2 armed only, ch3 silent
    n = cyc;
    drive(1'b1, 4'b0000, 0, 0, 0, 0);
    push(1, 70, 4'b0011, 1, n + Tmo + 5);
    drive(1'b0, 4'b0011, 7, 7, 7, 7);
    drive(1'b0, 4'b0100, 7, 7, 7, 7);
    drive(1'b0, 4'b0001, 40, 0, 0, 0);
    drive(1'b0, 4'b0010, 0, 70, 0, 0);
    wait_empty(Tmo + 50);

    // Round D: no strobes at all
    n = cyc;
    drive(1'b1, 4'b0000, 0, 0, 0, 0);
    push(0, 0, 4'b0000, 1, n + Tmo + 5);
    wait_empty(Tmo + 50);

    // Round E: reset asserted during CMP aborts with no done
    drive(1'b1, 4'b0000, 0, 0, 0, 0);
    drive(1'b0, 4'b1111, 0, 0, 0, 0);
    drive(1'b0, 4'b1111, 11, 22, 33, 44);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("abort_busy", int'(o_busy), 0);
    chk("abort_winner", int'(o_winner), 0);
    chk("abort_win_count", int'(o_win_count), 0);
    chk("abort_mask", int'(o_valid_mask), 0);
    chk("abort_timeout", int'(o_timeout), 0);
    idle(10);

    // Round F: normal round after the abort
    drive(1'b1, 4'b0000, 0, 0, 0, 0);
    drive(1'b0, 4'b1111, 5, 5, 5, 5);
    n = cyc;
    drive(1'b0, 4'b1111, 7, 8, 9, 4095);
    push(3, 4095, 4'b1111, 0, n + 6);
    wait_empty(50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
